// File: rtl/spi_adxl362_responder.sv
// spi_adxl362_responder: SPI mode-0 responder emulating the ADXL362 register interface
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   sclk, cs, mosi        SPI inputs from the controller (sclk idle low, cs active low)
//   miso, miso_oe         serial read data (MSB first, 0 when idle) and its drive enable
//   busy                  high while synchronized cs is low
//   reg_wr                one-clk pulse per committed register write
//   reg_addr, reg_wdata   address and data of the last committed write
//   soft_reset            one-clk pulse when 0x52 is committed to 0x1F
module spi_adxl362_responder #(
   parameter int CLK_FREQUENCY  = 100_000_000,
   parameter int SCLK_FREQUENCY = 1_000_000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       cs,
   input  logic       mosi,
   output logic       miso,
   output logic       miso_oe,
   output logic       busy,
   output logic       reg_wr,
   output logic [5:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       soft_reset
);
   typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA_RD, DATA_WR, IGNORE} state_t;
   state_t state_q, state_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, cs_sync_q, cs_sync_d, mosi_sync_q, mosi_sync_d;
   logic [SYNC_STAGES:0] vld_q, vld_d;
   logic sclk_s, cs_s, mosi_s;
   logic sclk_p_q, sclk_p_d, cs_p_q, cs_p_d;
   logic rise_q, rise_d, fall_q, fall_d, cs_fall_q, cs_fall_d, cs_rise_q, cs_rise_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] sh_q, sh_d, tx_q, tx_d;
   logic rd_q, rd_d;
   logic [5:0] addr_q, addr_d;
   logic miso_q, miso_d, miso_oe_q, miso_oe_d, reg_wr_q, reg_wr_d, soft_reset_q, soft_reset_d;
   logic [5:0] reg_addr_q, reg_addr_d;
   logic [7:0] reg_wdata_q, reg_wdata_d;
   logic [7:0] regs_q [64];
   logic [7:0] regs_d [64];
   logic [7:0] rst_regs [64];
   logic [7:0] byte_in, nxt;
   logic last;

   function automatic logic [7:0] rst_val(input logic [5:0] a);
      return a == 6'h00 ? 8'hAD : a == 6'h01 ? 8'h1D : a == 6'h02 ? 8'hF2 :
             a == 6'h03 ? 8'h01 : a == 6'h0B ? 8'h40 : a == 6'h2C ? 8'h13 : 8'h00;
   endfunction

   always_comb begin
      for (int i = 0; i < 64; i++) rst_regs[i] = rst_val(6'(i));
   end

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign busy      = ~cs_s;
   assign miso      = miso_q;
   assign miso_oe   = miso_oe_q;
   assign reg_wr    = reg_wr_q;
   assign reg_addr  = reg_addr_q;
   assign reg_wdata = reg_wdata_q;
   assign soft_reset = soft_reset_q;

   // vld marks when the synchronizer holds real pin samples; until then a cs held
   // low across reset must not look like a fresh cs_fall.
   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      vld_d       = {vld_q[SYNC_STAGES-1:0], 1'b1};
      sclk_p_d    = sclk_s;
      cs_p_d      = cs_s;
      rise_d      = sclk_s & ~sclk_p_q & ~cs_s;
      fall_d      = ~sclk_s & sclk_p_q & ~cs_s;
      cs_fall_d   = ~cs_s & cs_p_q & (&vld_q);
      cs_rise_d   = cs_s & ~cs_p_q;
   end

   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      sh_d = sh_q;
      rd_d = rd_q;
      addr_d = addr_q;
      tx_d = tx_q;
      miso_d = miso_q;
      miso_oe_d = miso_oe_q;
      reg_wr_d = 1'b0;
      reg_addr_d = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      soft_reset_d = 1'b0;
      regs_d = regs_q;
      byte_in = {sh_q[6:0], mosi_s};
      last = rise_q && cnt_q == 3'd7;
      nxt = regs_q[addr_q + 6'd1];
      if (cs_rise_q) begin
         state_d = IDLE;
         cnt_d = 3'd0;
         miso_d = 1'b0;
         miso_oe_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: if (cs_fall_q) begin
               state_d = CMD;
               cnt_d = 3'd0;
            end
            CMD: if (rise_q) begin
               sh_d = byte_in;
               cnt_d = cnt_q + 3'd1;
               if (last) begin
                  rd_d = byte_in == 8'h0B;
                  state_d = (byte_in == 8'h0B || byte_in == 8'h0A) ? ADDR : IGNORE;
               end
            end
            ADDR: if (rise_q) begin
               sh_d = byte_in;
               cnt_d = cnt_q + 3'd1;
               if (last) begin
                  addr_d = byte_in[5:0];
                  state_d = rd_q ? DATA_RD : DATA_WR;
                  tx_d = rd_q ? regs_q[byte_in[5:0]] : tx_q;
                  miso_d = rd_q & regs_q[byte_in[5:0]][7];
                  miso_oe_d = rd_q;
               end
            end
            // cnt_q == 0 means no rise yet in this byte: the MSB is already on miso,
            // so the fall that follows the previous byte's 8th rise must not shift.
            DATA_RD: if (rise_q) begin
               cnt_d = cnt_q + 3'd1;
               if (last) begin
                  addr_d = addr_q + 6'd1;
                  tx_d = nxt;
                  miso_d = nxt[7];
               end
            end else if (fall_q && cnt_q != 3'd0) begin
               tx_d = {tx_q[6:0], 1'b0};
               miso_d = tx_q[6];
            end
            DATA_WR: if (rise_q) begin
               sh_d = byte_in;
               cnt_d = cnt_q + 3'd1;
               if (last) begin
                  addr_d = addr_q + 6'd1;
                  if (addr_q >= 6'h1F && addr_q <= 6'h2E) begin
                     regs_d[addr_q] = byte_in;
                     reg_wr_d = 1'b1;
                     reg_addr_d = addr_q;
                     reg_wdata_d = byte_in;
                     if (addr_q == 6'h1F && byte_in == 8'h52) begin
                        soft_reset_d = 1'b1;
                        regs_d = rst_regs;
                     end
                  end
               end
            end
            default: begin
               miso_d = 1'b0;
               miso_oe_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      assert (CLK_FREQUENCY >= 8 * SCLK_FREQUENCY && SYNC_STAGES >= 2);
      if (rst) begin
         sclk_sync_q <= '0;
         cs_sync_q <= '1;
         mosi_sync_q <= '0;
         vld_q <= '0;
         sclk_p_q <= 1'b0;
         cs_p_q <= 1'b1;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         cs_fall_q <= 1'b0;
         cs_rise_q <= 1'b0;
         state_q <= IDLE;
         cnt_q <= 3'd0;
         sh_q <= 8'h00;
         rd_q <= 1'b0;
         addr_q <= 6'd0;
         tx_q <= 8'h00;
         miso_q <= 1'b0;
         miso_oe_q <= 1'b0;
         reg_wr_q <= 1'b0;
         reg_addr_q <= 6'd0;
         reg_wdata_q <= 8'h00;
         soft_reset_q <= 1'b0;
         regs_q <= rst_regs;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         cs_sync_q <= cs_sync_d;
         mosi_sync_q <= mosi_sync_d;
         vld_q <= vld_d;
         sclk_p_q <= sclk_p_d;
         cs_p_q <= cs_p_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         cs_fall_q <= cs_fall_d;
         cs_rise_q <= cs_rise_d;
         state_q <= state_d;
         cnt_q <= cnt_d;
         sh_q <= sh_d;
         rd_q <= rd_d;
         addr_q <= addr_d;
         tx_q <= tx_d;
         miso_q <= miso_d;
         miso_oe_q <= miso_oe_d;
         reg_wr_q <= reg_wr_d;
         reg_addr_q <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         soft_reset_q <= soft_reset_d;
         regs_q <= regs_d;
      end
   end
endmodule

// File: tb/tb_spi_adxl362_responder.sv
// tb_spi_adxl362_responder: table, hand-written and random SPI transactions against a register-file model
module tb_spi_adxl362_responder;
   localparam int H = 6;
   logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
   logic miso, miso_oe, busy, reg_wr, soft_reset;
   logic [5:0] reg_addr;
   logic [7:0] reg_wdata;
   int vectors = 0, miscompares = 0;
   int wr_cnt = 0, sr_cnt = 0, quiet_err = 0, busy_bad = 0;
   bit quiet = 1'b0;
   logic [7:0] txq[$], rxq[$];
   bit oe_all[$], oe_any[$];
   logic [7:0] m_regs [64];
   logic [7:0] m_exp[$];
   int m_wr = 0, m_sr = 0;
   logic [5:0] m_la;
   logic [7:0] m_ld;
   typedef struct {
      logic [7:0] cmd;
      logic [7:0] addr;
      logic [7:0] wd;
      int n;
      logic [31:0] rd;
      int wr;
      int sr;
   } vec_t;
   vec_t tbl[12];

   spi_adxl362_responder dut (
      .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe), .busy(busy), .reg_wr(reg_wr),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .soft_reset(soft_reset)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (reg_wr) wr_cnt <= wr_cnt + 1;
      if (soft_reset) sr_cnt <= sr_cnt + 1;
      if (quiet && (miso || miso_oe)) quiet_err <= quiet_err + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] m_rst(input int a);
      case (a)
         0: return 8'hAD;
         1: return 8'h1D;
         2: return 8'hF2;
         3: return 8'h01;
         11: return 8'h40;
         44: return 8'h13;
         default: return 8'h00;
      endcase
   endfunction

   task automatic m_regs_reset();
      for (int i = 0; i < 64; i++) m_regs[i] = m_rst(i);
   endtask

   task automatic m_full_reset();
      m_regs_reset();
      m_la = 6'd0;
      m_ld = 8'h00;
   endtask

   // Transaction-level reference: byte 0 is the command, byte 1 the address,
   // every later complete byte touches one register and moves to the next (mod 64).
   task automatic m_txn(input int nfull);
      int a;
      m_exp.delete();
      if (nfull < 2) return;
      a = int'(txq[1]) % 64;
      for (int k = 2; k < nfull; k++) begin
         if (txq[0] == 8'h0B) m_exp.push_back(m_regs[a]);
         else if (txq[0] == 8'h0A && a >= 31 && a <= 46) begin
            m_regs[a] = txq[k];
            m_wr++;
            m_la = 6'(a);
            m_ld = txq[k];
            if (a == 31 && txq[k] == 8'h52) begin
               m_sr++;
               m_regs_reset();
            end
         end
         a = (a + 1) % 64;
      end
   endtask

   task automatic xfer(input int last_bits, input int rst_bit);
      int nb = txq.size();
      int k = 0;
      rxq.delete();
      oe_all.delete();
      oe_any.delete();
      cs = 1'b0;
      repeat (H) @(negedge clk);
      for (int i = 0; i < nb; i++) begin
         logic [7:0] r = 8'h00;
         bit a1 = 1'b1, a0 = 1'b0;
         int lo = (i == nb - 1) ? 8 - last_bits : 0;
         for (int j = 7; j >= lo; j--) begin
            if (k == rst_bit) begin
               rst = 1'b1;
               @(negedge clk);
               rst = 1'b0;
            end
            mosi = txq[i][j];
            repeat (H) @(negedge clk);
            r[j] = miso;
            a1 &= miso_oe;
            a0 |= miso_oe;
            if (busy !== 1'b1) busy_bad++;
            sclk = 1'b1;
            repeat (H) @(negedge clk);
            sclk = 1'b0;
            k++;
         end
         rxq.push_back(r);
         oe_all.push_back(a1);
         oe_any.push_back(a0);
      end
      repeat (H) @(negedge clk);
      cs = 1'b1;
      mosi = 1'b0;
      repeat (3 * H) @(negedge clk);
   endtask

   task automatic run(input int last_bits, input int rst_bit);
      if (rst_bit >= 0) begin
         m_txn(rst_bit / 8);
         m_full_reset();
      end else m_txn(last_bits == 8 ? txq.size() : txq.size() - 1);
      quiet = (txq[0] != 8'h0B);
      xfer(last_bits, rst_bit);
      quiet = 1'b0;
   endtask

   function automatic bit oe_ok();
      for (int i = 0; i < oe_all.size(); i++)
         if (i >= 2 ? !oe_all[i] : oe_any[i]) return 1'b0;
      return 1'b1;
   endfunction

   initial begin
      int w0, s0, q0;
      tbl[0]  = '{8'h0B, 8'h00, 8'h00, 1, 32'hAD00_0000, 0, 0};
      tbl[1]  = '{8'h0B, 8'h00, 8'h00, 4, 32'hAD1D_F201, 0, 0};
      tbl[2]  = '{8'h0B, 8'h3F, 8'h00, 2, 32'h00AD_0000, 0, 0};
      tbl[3]  = '{8'h0A, 8'h20, 8'h5A, 1, 32'h0, 1, 0};
      tbl[4]  = '{8'h0B, 8'h20, 8'h00, 1, 32'h5A00_0000, 0, 0};
      tbl[5]  = '{8'h0A, 8'h00, 8'hFF, 1, 32'h0, 0, 0};
      tbl[6]  = '{8'h0B, 8'h00, 8'h00, 1, 32'hAD00_0000, 0, 0};
      tbl[7]  = '{8'h0A, 8'h20, 8'h5A, 1, 32'h0, 1, 0};
      tbl[8]  = '{8'h0A, 8'h1F, 8'h52, 1, 32'h0, 1, 1};
      tbl[9]  = '{8'h0B, 8'h20, 8'h00, 1, 32'h0000_0000, 0, 0};
      tbl[10] = '{8'h0B, 8'h2C, 8'h00, 1, 32'h1300_0000, 0, 0};
      tbl[11] = '{8'h0B, 8'h0B, 8'h00, 1, 32'h4000_0000, 0, 0};
      m_full_reset();
      repeat (4) @(negedge clk);
      chk("rst_miso", miso, 0);
      chk("rst_miso_oe", miso_oe, 0);
      chk("rst_busy", busy, 0);
      chk("rst_reg_wr", reg_wr, 0);
      chk("rst_reg_addr", reg_addr, 0);
      chk("rst_reg_wdata", reg_wdata, 0);
      chk("rst_soft_reset", soft_reset, 0);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      foreach (tbl[v]) begin
         w0 = wr_cnt;
         s0 = sr_cnt;
         q0 = quiet_err;
         txq = {tbl[v].cmd, tbl[v].addr};
         for (int k = 0; k < tbl[v].n; k++) txq.push_back(tbl[v].wd);
         run(8, -1);
         if (tbl[v].cmd == 8'h0B) begin
            for (int k = 0; k < tbl[v].n; k++)
               chk($sformatf("tbl%0d_rd%0d", v, k), rxq[2 + k], tbl[v].rd[31 - 8 * k -: 8]);
            chk($sformatf("tbl%0d_oe", v), oe_ok(), 1);
         end else chk($sformatf("tbl%0d_quiet", v), quiet_err - q0, 0);
         chk($sformatf("tbl%0d_wr", v), wr_cnt - w0, tbl[v].wr);
         chk($sformatf("tbl%0d_sr", v), sr_cnt - s0, tbl[v].sr);
         if (tbl[v].wr != 0) begin
            chk($sformatf("tbl%0d_reg_addr", v), reg_addr, tbl[v].addr[5:0]);
            chk($sformatf("tbl%0d_reg_wdata", v), reg_wdata, tbl[v].wd);
         end
         chk($sformatf("tbl%0d_idle", v), {miso, miso_oe, busy}, 0);
      end

      w0 = wr_cnt;
      txq = {8'h0A, 8'h21, 8'hAA};
      run(5, -1);
      chk("abort_wr", wr_cnt - w0, 0);
      txq = {8'h0B, 8'h21, 8'h00};
      run(8, -1);
      chk("abort_rd21", rxq[2], 8'h00);

      q0 = quiet_err;
      txq = {8'h0D, 8'h00, 8'hFF, 8'hFF};
      run(8, -1);
      chk("illegal_quiet", quiet_err - q0, 0);

      txq = {8'h0A, 8'h22, 8'h77};
      run(8, -1);
      chk("pre_rst_reg_addr", reg_addr, 6'h22);
      w0 = wr_cnt;
      txq = {8'h0A, 8'h23, 8'h44};
      run(8, 11);
      chk("midrst_wr", wr_cnt - w0, 0);
      chk("midrst_reg_addr", reg_addr, 0);
      chk("midrst_reg_wdata", reg_wdata, 0);
      txq = {8'h0B, 8'h22, 8'h00};
      run(8, -1);
      chk("midrst_rd22", rxq[2], 8'h00);
      chk("busy_during_txn", busy_bad, 0);

      for (int t = 0; t < 30; t++) begin
         int sel = $urandom_range(0, 9);
         int n = $urandom_range(1, 3);
         logic [7:0] c, a;
         c = sel < 4 ? 8'h0B : sel < 8 ? 8'h0A : 8'($urandom_range(0, 255));
         if (sel >= 8 && (c == 8'h0A || c == 8'h0B)) c = 8'h0D;
         a = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 1) == 1) a = {a[7:6], 6'($urandom_range(31, 46))};
         txq = {c, a};
         for (int k = 0; k < n; k++) txq.push_back(8'($urandom_range(0, 255)));
         q0 = quiet_err;
         run(8, -1);
         if (c == 8'h0B) begin
            for (int k = 0; k < m_exp.size(); k++)
               chk($sformatf("rnd%0d_rd%0d", t, k), rxq[2 + k], m_exp[k]);
            chk($sformatf("rnd%0d_oe", t), oe_ok(), 1);
         end else chk($sformatf("rnd%0d_quiet", t), quiet_err - q0, 0);
         chk($sformatf("rnd%0d_wr", t), wr_cnt, m_wr);
         chk($sformatf("rnd%0d_sr", t), sr_cnt, m_sr);
         chk($sformatf("rnd%0d_reg_addr", t), reg_addr, m_la);
         chk($sformatf("rnd%0d_reg_wdata", t), reg_wdata, m_ld);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
